jpeg_dequant: RTL and testbench

JPEG_DEQUANT -- requirements
Module: jpeg_dequant

---
 rtl/jpeg_dequant_pkg.sv | 28 ++
 rtl/jpeg_dequant_ram.sv | 43 ++++
 rtl/jpeg_dequant.sv | 149 ++++++++++++++
 tb/tb_jpeg_dequant.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_dequant_pkg.sv
// rtl/jpeg_dequant_pkg.sv - shared widths and zigzag LUT for the dequantiser
//
// Purpose: constants shared by jpeg_dequant and jpeg_dequant_ram.
//   COEF_W  : signed coefficient width
//   QUANT_W : unsigned quantiser width
//   PROD_W  : signed product width
//   ZZ_TO_NAT[k] : natural (row-major) position of zigzag position k
package jpeg_dequant_pkg;

    localparam int COEF_W  = 16;
    localparam int QUANT_W = 8;
    localparam int PROD_W  = 24;
    localparam int IDX_W   = 6;
    localparam int TBL_W   = 2;
    localparam int ADDR_W  = TBL_W + IDX_W;

    localparam logic [IDX_W-1:0] ZZ_TO_NAT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/jpeg_dequant_ram.sv
// rtl/jpeg_dequant_ram.sv - 256x8 quantisation table store, 1W/1R synchronous
//
// Purpose: holds four 64-entry quantiser tables addressed by {table, zigzag idx}.
// Ports:
//   clk_i      : clock
//   wr_en_i    : write strobe, write lands at the rising edge
//   wr_addr_i  : write address
//   wr_data_i  : write data
//   rd_en_i    : read enable; rd_data_o holds when low
//   rd_addr_i  : read address
//   rd_data_o  : registered read data (old value on same-edge read/write)
// Contents are not reset.
import jpeg_dequant_pkg::*;

module jpeg_dequant_ram (
    input  logic               clk_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [QUANT_W-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [QUANT_W-1:0] rd_data_o
);

    logic [QUANT_W-1:0] mem_q [256];
    logic [QUANT_W-1:0] rd_data_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read samples the array before this edge's write lands: read-old-data.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/jpeg_dequant.sv
// rtl/jpeg_dequant.sv - two-stage JPEG coefficient dequantiser with de-zigzag
//
// Purpose: S1 looks up the quantiser and maps zigzag to natural order,
// S2 multiplies and registers the result. Valid/accept handshake both sides.
// Ports:
//   clk_i, rst_i (async, active-low)
//   img_start_i        : synchronous flush of both stages
//   dqt_wr_i/dqt_table_i/dqt_idx_i/dqt_data_i : quant table write
//   inport_*           : coefficient input (zigzag idx, table, eob)
//   outport_*          : dequantised output (natural idx, eob)
// Macro JPEG_DEQUANT_SATURATE_EN: clamp product to 16-bit signed range;
// undefined, the output is the low 16 bits of the product.
import jpeg_dequant_pkg::*;

module jpeg_dequant (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               img_start_i,
    input  logic               dqt_wr_i,
    input  logic [TBL_W-1:0]   dqt_table_i,
    input  logic [IDX_W-1:0]   dqt_idx_i,
    input  logic [QUANT_W-1:0] dqt_data_i,
    input  logic               inport_valid_i,
    input  logic [COEF_W-1:0]  inport_data_i,
    input  logic [IDX_W-1:0]   inport_idx_i,
    input  logic [TBL_W-1:0]   inport_table_i,
    input  logic               inport_eob_i,
    output logic               inport_accept_o,
    output logic               outport_valid_o,
    output logic [COEF_W-1:0]  outport_data_o,
    output logic [IDX_W-1:0]   outport_idx_o,
    output logic               outport_eob_o,
    input  logic               outport_accept_i
);

    logic                s1_adv;
    logic                s2_adv;

    logic                s1_valid_q, s1_valid_d;
    logic [COEF_W-1:0]   s1_coef_q,  s1_coef_d;
    logic [IDX_W-1:0]    s1_idx_q,   s1_idx_d;
    logic                s1_eob_q,   s1_eob_d;
    logic [QUANT_W-1:0]  s1_quant;

    logic                out_valid_q, out_valid_d;
    logic [COEF_W-1:0]   out_data_q,  out_data_d;
    logic [IDX_W-1:0]    out_idx_q,   out_idx_d;
    logic                out_eob_q,   out_eob_d;

    logic signed [PROD_W-1:0] prod;
    logic [COEF_W-1:0]        prod_res;

    assign s2_adv          = !out_valid_q || outport_accept_i;
    assign s1_adv          = !s1_valid_q || s2_adv;
    assign inport_accept_o = s1_adv;

    // The RAM output register is the S1 quantiser field, so it only
    // reloads when S1 loads; a stalled S1 keeps its looked-up value.
    jpeg_dequant_ram u_ram (
        .clk_i     (clk_i),
        .wr_en_i   (dqt_wr_i),
        .wr_addr_i ({dqt_table_i, dqt_idx_i}),
        .wr_data_i (dqt_data_i),
        .rd_en_i   (s1_adv),
        .rd_addr_i ({inport_table_i, inport_idx_i}),
        .rd_data_o (s1_quant)
    );

    // Signed coefficient times zero-extended quantiser; the true product
    // always fits in 24 signed bits.
    assign prod = $signed({{(PROD_W-COEF_W){s1_coef_q[COEF_W-1]}}, s1_coef_q})
                * $signed({{(PROD_W-QUANT_W){1'b0}}, s1_quant});

`ifdef JPEG_DEQUANT_SATURATE_EN
    always_comb begin
        prod_res = prod[COEF_W-1:0];
        if (prod > 24'sd32767) begin
            prod_res = 16'h7FFF;
        end else if (prod < -24'sd32768) begin
            prod_res = 16'h8000;
        end
    end
`else
    logic unused_prod_hi;
    assign unused_prod_hi = ^prod[PROD_W-1:COEF_W];
    assign prod_res       = prod[COEF_W-1:0];
`endif

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_coef_d  = s1_coef_q;
        s1_idx_d   = s1_idx_q;
        s1_eob_d   = s1_eob_q;
        if (img_start_i) begin
            s1_valid_d = 1'b0;
        end else if (s1_adv) begin
            s1_valid_d = inport_valid_i;
            s1_coef_d  = inport_data_i;
            s1_idx_d   = ZZ_TO_NAT[inport_idx_i];
            s1_eob_d   = inport_eob_i;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_idx_d   = out_idx_q;
        out_eob_d   = out_eob_q;
        if (img_start_i) begin
            out_valid_d = 1'b0;
            out_eob_d   = 1'b0;
        end else if (s2_adv) begin
            out_valid_d = s1_valid_q;
            out_eob_d   = s1_valid_q && s1_eob_q;
            if (s1_valid_q) begin
                out_data_d = prod_res;
                out_idx_d  = s1_idx_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s1_valid_q  <= 1'b0;
            s1_coef_q   <= '0;
            s1_idx_q    <= '0;
            s1_eob_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_eob_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_coef_q   <= s1_coef_d;
            s1_idx_q    <= s1_idx_d;
            s1_eob_q    <= s1_eob_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_idx_q   <= out_idx_d;
            out_eob_q   <= out_eob_d;
        end
    end

    assign outport_valid_o = out_valid_q;
    assign outport_data_o  = out_data_q;
    assign outport_idx_o   = out_idx_q;
    assign outport_eob_o   = out_eob_q;

endmodule

// File: tb/tb_jpeg_dequant.sv
// tb/tb_jpeg_dequant.sv - self-checking bench for jpeg_dequant
module tb_jpeg_dequant;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        img_start_i;
    logic        dqt_wr_i;
    logic [1:0]  dqt_table_i;
    logic [5:0]  dqt_idx_i;
    logic [7:0]  dqt_data_i;
    logic        inport_valid_i;
    logic [15:0] inport_data_i;
    logic [5:0]  inport_idx_i;
    logic [1:0]  inport_table_i;
    logic        inport_eob_i;
    logic        inport_accept_o;
    logic        outport_valid_o;
    logic [15:0] outport_data_o;
    logic [5:0]  outport_idx_o;
    logic        outport_eob_o;
    logic        outport_accept_i;

    jpeg_dequant dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .img_start_i      (img_start_i),
        .dqt_wr_i         (dqt_wr_i),
        .dqt_table_i      (dqt_table_i),
        .dqt_idx_i        (dqt_idx_i),
        .dqt_data_i       (dqt_data_i),
        .inport_valid_i   (inport_valid_i),
        .inport_data_i    (inport_data_i),
        .inport_idx_i     (inport_idx_i),
        .inport_table_i   (inport_table_i),
        .inport_eob_i     (inport_eob_i),
        .inport_accept_o  (inport_accept_o),
        .outport_valid_o  (outport_valid_o),
        .outport_data_o   (outport_data_o),
        .outport_idx_o    (outport_idx_o),
        .outport_eob_o    (outport_eob_o),
        .outport_accept_i (outport_accept_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [15:0] data;
        logic [5:0]  idx;
        logic        eob;
    } exp_t;

    int          n_cmp = 0;
    int          n_err = 0;
    int          n_in  = 0;
    exp_t        exp_q[$];
    logic [7:0]  mdl_tbl [4][64];
    int          nat_of_zz [64];

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Zigzag walk over anti-diagonals: even diagonals run up (row falling),
    // odd diagonals run down (row rising).
    function automatic void build_zigzag();
        int k = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int r = hi; r >= lo; r--) begin
                    nat_of_zz[k] = r * 8 + (s - r);
                    k++;
                end
            end else begin
                for (int r = lo; r <= hi; r++) begin
                    nat_of_zz[k] = r * 8 + (s - r);
                    k++;
                end
            end
        end
    endfunction

    function automatic logic [15:0] model_deq(input logic [15:0] c, input logic [7:0] q);
        int p;
        p = int'($signed(c)) * int'(q);
`ifdef JPEG_DEQUANT_SATURATE_EN
        if (p > 32767) p = 32767;
        else if (p < -32768) p = -32768;
`endif
        return p[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe transfers mid-cycle, update the model, then move
    // to just after the next rising edge where inputs may change.
    task automatic step();
        exp_t e;
        @(negedge clk_i);
        if (rst_i) begin
            if (outport_valid_o && outport_accept_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'(outport_data_o), 32'hDEAD_BEEF);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data_idx_eob",
                          32'({outport_data_o, outport_idx_o, outport_eob_o}), 32'(e));
                end
            end
            if (!outport_valid_o) begin
                check("eob_idle", 32'(outport_eob_o), 32'd0);
            end
            if (img_start_i) begin
                exp_q.delete();
            end else if (inport_valid_i && inport_accept_o) begin
                e.data = model_deq(inport_data_i, mdl_tbl[inport_table_i][inport_idx_i]);
                e.idx  = 6'(nat_of_zz[inport_idx_i]);
                e.eob  = inport_eob_i;
                exp_q.push_back(e);
                n_in++;
            end
            if (dqt_wr_i) begin
                mdl_tbl[dqt_table_i][dqt_idx_i] = dqt_data_i;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr_tbl(input logic [1:0] t, input logic [5:0] i, input logic [7:0] v);
        dqt_wr_i    = 1'b1;
        dqt_table_i = t;
        dqt_idx_i   = i;
        dqt_data_i  = v;
        step();
        dqt_wr_i    = 1'b0;
    endtask

    task automatic send(input logic [15:0] c, input logic [5:0] i, input logic [1:0] t, input logic eob);
        int  guard = 0;
        bit  taken;
        inport_valid_i = 1'b1;
        inport_data_i  = c;
        inport_idx_i   = i;
        inport_table_i = t;
        inport_eob_i   = eob;
        do begin
            taken = inport_accept_o;
            step();
            guard++;
        end while (!taken && guard < 100);
        if (!taken) check("send_timeout", 32'(guard), 32'd0);
        inport_valid_i = 1'b0;
        inport_eob_i   = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        outport_accept_i = 1'b1;
        while ((exp_q.size() != 0 || outport_valid_o) && guard < 200) begin
            step();
            guard++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0]  v_old;
        logic [15:0] c;
        int          k;
        int          in0;

        build_zigzag();
        rst_i = 1'b0;
        img_start_i = 1'b0;
        dqt_wr_i = 1'b0; dqt_table_i = '0; dqt_idx_i = '0; dqt_data_i = '0;
        inport_valid_i = 1'b0; inport_data_i = '0; inport_idx_i = '0;
        inport_table_i = '0; inport_eob_i = 1'b0;
        outport_accept_i = 1'b1;

        repeat (2) @(posedge clk_i);
        #1;
        check("rst_valid",  32'(outport_valid_o), 32'd0);
        check("rst_eob",    32'(outport_eob_o),   32'd0);
        check("rst_data",   32'(outport_data_o),  32'd0);
        check("rst_idx",    32'(outport_idx_o),   32'd0);
        check("rst_accept", 32'(inport_accept_o), 32'd1);
        rst_i = 1'b1;

        for (int t = 0; t < 4; t++)
            for (int i = 0; i < 64; i++)
                wr_tbl(2'(t), 6'(i), 8'($urandom_range(0, 255)));

        // Basic latency example: 5 * 16 = 80 at natural idx 0.
        wr_tbl(2'd1, 6'd0, 8'd16);
        send(16'd5, 6'd0, 2'd1, 1'b0);
        check("lat_cycle1_valid", 32'(outport_valid_o), 32'd0);
        step();
        check("lat_cycle2_valid", 32'(outport_valid_o), 32'd1);
        check("lat_cycle2_data",  32'(outport_data_o),  32'd80);
        check("lat_cycle2_idx",   32'(outport_idx_o),   32'd0);
        drain();

        // Zero coefficient gives zero regardless of the quantiser.
        wr_tbl(2'd0, 6'd10, 8'd200);
        send(16'd0, 6'd10, 2'd0, 1'b0);
        step();
        check("zero_coef", 32'(outport_data_o), 32'd0);
        check("zero_idx",  32'(outport_idx_o),  32'(nat_of_zz[10]));
        drain();

        // Full block through an all-ones table, back to back.
        for (int i = 0; i < 64; i++) wr_tbl(2'd2, 6'(i), 8'd1);
        for (int i = 0; i < 64; i++)
            send(16'($urandom), 6'(i), 2'd2, i == 63);
        drain();

        // Overflow example: 1000 * 255 = 255000.
        wr_tbl(2'd3, 6'd5, 8'd255);
        send(16'd1000, 6'd5, 2'd3, 1'b0);
        step();
`ifdef JPEG_DEQUANT_SATURATE_EN
        check("ovf_pos", 32'(outport_data_o), 32'h7FFF);
`else
        check("ovf_pos", 32'(outport_data_o), 32'hE418);
`endif
        drain();
        send(-16'sd1000, 6'd5, 2'd3, 1'b0);
        drain();

        // Same-cycle write and read of one entry: old value, then new.
        v_old = mdl_tbl[0][7];
        dqt_wr_i = 1'b1; dqt_table_i = 2'd0; dqt_idx_i = 6'd7; dqt_data_i = v_old ^ 8'h5A;
        send(16'd3, 6'd7, 2'd0, 1'b0);
        dqt_wr_i = 1'b0;
        step();
        check("rdw_old", 32'(outport_data_o), 32'(model_deq(16'd3, v_old)));
        drain();
        send(16'd3, 6'd7, 2'd0, 1'b0);
        step();
        check("rdw_new", 32'(outport_data_o), 32'(model_deq(16'd3, v_old ^ 8'h5A)));
        drain();

        // Downstream stall from an empty pipe: two transfers fill it.
        outport_accept_i = 1'b0;
        in0 = n_in;
        k = 0;
        inport_valid_i = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) begin
            inport_data_i  = 16'(100 + k);
            inport_idx_i   = 6'(k);
            inport_table_i = 2'(k);
            if (inport_accept_o) k++;
            step();
        end
        check("stall_transfers", 32'(n_in - in0), 32'd2);
        check("stall_accept",    32'(inport_accept_o), 32'd0);
        check("stall_out_valid", 32'(outport_valid_o), 32'd1);
        outport_accept_i = 1'b1;
        for (int cyc = 0; cyc < 6; cyc++) begin
            inport_data_i  = 16'(100 + k);
            inport_idx_i   = 6'(k);
            inport_table_i = 2'(k);
            if (inport_accept_o) k++;
            step();
        end
        inport_valid_i = 1'b0;
        drain();

        // Random traffic with random backpressure and concurrent table writes.
        for (int cyc = 0; cyc < 400; cyc++) begin
            inport_valid_i   = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 4))
                0: c = 16'h8000;
                1: c = 16'h7FFF;
                2: c = 16'd0;
                default: c = 16'($urandom);
            endcase
            inport_data_i    = c;
            inport_idx_i     = 6'($urandom_range(0, 63));
            inport_table_i   = 2'($urandom_range(0, 3));
            inport_eob_i     = ($urandom_range(0, 7) == 0);
            outport_accept_i = ($urandom_range(0, 2) != 0);
            dqt_wr_i         = ($urandom_range(0, 5) == 0);
            dqt_table_i      = 2'($urandom_range(0, 3));
            dqt_idx_i        = 6'($urandom_range(0, 63));
            dqt_data_i       = 8'($urandom);
            step();
        end
        inport_valid_i = 1'b0;
        inport_eob_i   = 1'b0;
        dqt_wr_i       = 1'b0;
        drain();

        // Flush with both stages full.
        outport_accept_i = 1'b0;
        inport_valid_i = 1'b1;
        inport_data_i = 16'd7; inport_idx_i = 6'd1; inport_table_i = 2'd1;
        repeat (3) step();
        check("flush_pre_valid", 32'(outport_valid_o), 32'd1);
        inport_valid_i = 1'b0;
        img_start_i = 1'b1;
        step();
        img_start_i = 1'b0;
        check("flush_valid",  32'(outport_valid_o), 32'd0);
        check("flush_eob",    32'(outport_eob_o),   32'd0);
        check("flush_accept", 32'(inport_accept_o), 32'd1);

        // Asynchronous reset in the middle of a stream.
        outport_accept_i = 1'b1;
        inport_valid_i = 1'b1;
        inport_data_i = 16'd9; inport_idx_i = 6'd2; inport_table_i = 2'd2;
        repeat (3) step();
        #2;
        rst_i = 1'b0;
        #1;
        check("arst_valid",  32'(outport_valid_o), 32'd0);
        check("arst_eob",    32'(outport_eob_o),   32'd0);
        check("arst_data",   32'(outport_data_o),  32'd0);
        check("arst_accept", 32'(inport_accept_o), 32'd1);
        exp_q.delete();
        inport_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;

        // Tables survive flush and reset.
        for (int i = 0; i < 24; i++)
            send(16'($urandom_range(0, 255)), 6'($urandom_range(0, 63)),
                 2'($urandom_range(0, 3)), 1'b0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
